// File: rtl/idct_frame_seq.sv
`default_nettype none
// ============================================================================
//  Module      : idct_frame_seq
//  Description : Frame sequencer ahead of the IDCT IFFT + scaling chain.
//                Accepts one size command per frame, frames the raw sample
//                stream into Avalon-ST packets (sop/eop, held fftpts), limits
//                frames in flight, and reports saturating per-frame overflow
//                counts from the scaling stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module idct_frame_seq #(
    parameter int wData        = 28,
    parameter int wOvfCnt      = 12,
    parameter int MAX_INFLIGHT = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [11:0]        cmd_fftpts,
    output logic               cmd_err,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [wData-1:0]   in_real,
    input  logic [wData-1:0]   in_imag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_sop,
    output logic               out_eop,
    output logic [wData-1:0]   out_real,
    output logic [wData-1:0]   out_imag,
    output logic [11:0]        out_fftpts,
    input  logic               mon_valid,
    input  logic               mon_eop,
    input  logic               mon_overflow,
    output logic               stat_valid,
    output logic [wOvfCnt-1:0] stat_ovf_cnt,
    output logic [2:0]         inflight
);

    localparam logic [0:0]         c_S_IDLE   = 1'b0;
    localparam logic [0:0]         c_S_RUN    = 1'b1;
    localparam logic [2:0]         c_MAX_FLT  = 3'(MAX_INFLIGHT);
    localparam logic [wOvfCnt-1:0] c_OVF_MAX  = '1;

    logic [0:0]         r_state;
    logic [0:0]         w_next_state;
    logic [11:0]        r_cnt;
    logic [11:0]        r_fftpts;
    logic               r_cmd_err;
    logic [2:0]         r_inflight;
    logic [wOvfCnt-1:0] r_acc;
    logic               r_stat_valid;
    logic [wOvfCnt-1:0] r_stat_ovf_cnt;

    logic               w_legal;
    logic               w_accept_legal;
    logic               w_accept_bad;
    logic               w_beat;
    logic               w_issue;
    logic               w_retire;
    logic               w_last_cnt;
    logic               w_mon_end;
    logic [wOvfCnt-1:0] w_acc_sum;

    assign w_legal    = (cmd_fftpts == 12'd256)  || (cmd_fftpts == 12'd512) ||
                        (cmd_fftpts == 12'd1024) || (cmd_fftpts == 12'd2048);
    assign w_last_cnt = (r_cnt == (r_fftpts - 12'd1));
    assign w_mon_end  = mon_valid & mon_eop;
    // A retire with nothing in flight is ignored so the counter cannot wrap below zero.
    assign w_retire   = w_mon_end & (r_inflight != 3'd0);
    // The accumulator sticks at its maximum rather than wrapping.
    assign w_acc_sum  = ((r_acc != c_OVF_MAX) && mon_valid && mon_overflow) ?
                        r_acc + wOvfCnt'(1) : r_acc;

    assign out_fftpts   = r_fftpts;
    assign cmd_err      = r_cmd_err;
    assign inflight     = r_inflight;
    assign stat_valid   = r_stat_valid;
    assign stat_ovf_cnt = r_stat_ovf_cnt;

    // Next-state and handshake decode; RUN is a zero-latency pass-through.
    always_comb begin
        w_next_state   = r_state;
        cmd_ready      = 1'b0;
        in_ready       = 1'b0;
        out_valid      = 1'b0;
        out_sop        = 1'b0;
        out_eop        = 1'b0;
        out_real       = '0;
        out_imag       = '0;
        w_beat         = 1'b0;
        w_issue        = 1'b0;
        w_accept_legal = 1'b0;
        w_accept_bad   = 1'b0;
        case (r_state)
            c_S_IDLE: begin
                cmd_ready = (r_inflight < c_MAX_FLT);
                if (cmd_valid && cmd_ready) begin
                    if (w_legal) begin
                        w_accept_legal = 1'b1;
                        w_next_state   = c_S_RUN;
                    end else begin
                        w_accept_bad   = 1'b1;
                    end
                end
            end
            default: begin
                out_valid = in_valid;
                in_ready  = out_ready;
                out_real  = in_real;
                out_imag  = in_imag;
                out_sop   = in_valid && (r_cnt == 12'd0);
                out_eop   = in_valid && w_last_cnt;
                w_beat    = in_valid && out_ready;
                if (w_beat && w_last_cnt) begin
                    w_issue      = 1'b1;
                    w_next_state = c_S_IDLE;
                end
            end
        endcase
    end

    // State, beat counter, latched frame length and illegal-command pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= c_S_IDLE;
            r_cnt     <= 12'd0;
            r_fftpts  <= 12'd0;
            r_cmd_err <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_cmd_err <= w_accept_bad;
            if (w_accept_legal) begin
                r_fftpts <= cmd_fftpts;
                r_cnt    <= 12'd0;
            end else if (w_beat) begin
                r_cnt    <= r_cnt + 12'd1;
            end
        end
    end

    // Frames in flight: issue on the last framed beat, retire on scaling eop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inflight <= 3'd0;
        end else if (w_issue && !w_retire) begin
            r_inflight <= r_inflight + 3'd1;
        end else if (!w_issue && w_retire) begin
            r_inflight <= r_inflight - 3'd1;
        end
    end

    // Per-frame overflow accumulation; the eop beat itself is included in the report.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc          <= '0;
            r_stat_valid   <= 1'b0;
            r_stat_ovf_cnt <= '0;
        end else begin
            r_stat_valid <= w_mon_end;
            if (w_mon_end) begin
                r_stat_ovf_cnt <= w_acc_sum;
                r_acc          <= '0;
            end else begin
                r_acc          <= w_acc_sum;
            end
        end
    end

endmodule
`default_nettype wire
